// File: rtl/fetch_unit_if.sv
// Fetch-stage port bundle: instruction-memory req/ack handshake, hazard/redirect
// controls and the head-of-queue outputs; FETCH_STATS_EN adds the statistics counters.
interface fetch_unit_if;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] outPC;
  logic        valid;
`ifdef FETCH_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  modport master (
    input  stall, redirect_valid, redirect_pc, imem_ack, imem_rdata,
    output imem_req, imem_addr, instruction, outPC, valid, stall_cycles, flush_count
  );
  modport slave (
    output stall, redirect_valid, redirect_pc, imem_ack, imem_rdata,
    input  imem_req, imem_addr, instruction, outPC, valid, stall_cycles, flush_count
  );
`else
  modport master (
    input  stall, redirect_valid, redirect_pc, imem_ack, imem_rdata,
    output imem_req, imem_addr, instruction, outPC, valid
  );
  modport slave (
    output stall, redirect_valid, redirect_pc, imem_ack, imem_rdata,
    input  imem_req, imem_addr, instruction, outPC, valid
  );
`endif
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, runs a single-outstanding req/ack to
// instruction memory and buffers words in a prefetch queue. Optional: FETCH_STATS_EN.
//
// state  | meaning
// S_IDLE | no request outstanding; a new one may issue at fpc
// S_WAIT | request at areg accepted, waiting for its ack
// S_DROP | request at areg outstanding but flushed by a redirect; its data is dropped
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input logic          clk,
  input logic          reset,
  fetch_unit_if.master bus
);
  localparam int unsigned   AW   = $clog2(DEPTH);
  localparam int unsigned   CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} fstate_t;

  fstate_t       state, state_nx;
  logic [31:0]   fpc, fpc_nx;
  logic [31:0]   areg, areg_nx;
  logic [31:0]   pc_q   [DEPTH];
  logic [31:0]   word_q [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          inflight, has_room, req, acked, push, pop, head_valid, redirect;
  logic [31:0]   addr;

  assign redirect   = bus.redirect_valid;
  assign inflight   = (state != S_IDLE);
  assign has_room   = (count < FULL);
  assign head_valid = (count != '0);

  // Held low during reset so a half-finished handshake is abandoned at once.
  assign req   = ~reset & (inflight | (has_room & ~redirect));
  assign addr  = inflight ? areg : fpc;
  assign acked = req & bus.imem_ack;
  assign pop   = head_valid & ~bus.stall & ~redirect;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      fpc   <= RESET_PC;
      areg  <= RESET_PC;
    end else begin
      state <= state_nx;
      fpc   <= fpc_nx;
      areg  <= areg_nx;
    end
  end

  always_comb begin
    state_nx = state;
    fpc_nx   = fpc;
    areg_nx  = areg;
    push     = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (acked) begin
            push   = 1'b1;
            fpc_nx = addr + 32'd4;
          end else begin
            state_nx = S_WAIT;
            areg_nx  = fpc;
          end
        end
      end
      S_WAIT: begin
        if (acked) begin
          state_nx = S_IDLE;
          push     = 1'b1;
          fpc_nx   = addr + 32'd4;
        end else if (redirect) begin
          state_nx = S_DROP;
        end
      end
      S_DROP: begin
        if (acked) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    // A redirect overrides any push and retargets the fetch PC.
    if (redirect) begin
      push   = 1'b0;
      fpc_nx = bus.redirect_pc & ~32'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[wr_ptr]   <= addr;
      word_q[wr_ptr] <= bus.imem_rdata;
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = addr;
  assign bus.valid       = head_valid;
  assign bus.instruction = head_valid ? word_q[rd_ptr] : 32'h0000_0000;
  assign bus.outPC       = head_valid ? pc_q[rd_ptr] : 32'h0000_0000;

`ifdef FETCH_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (head_valid && bus.stall) stall_cnt <= stall_cnt + 32'd1;
      if (redirect)                flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_cnt;
  assign bus.flush_count  = flush_cnt;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: queue-level reference model, directed scenarios
// and a randomized run with random memory latency, stalls and redirects.
module tb_fetch_unit;
  localparam logic [31:0] RPC   = 32'h0040_0000;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;

  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [31:0] mq_pc[$];
  logic [31:0] mq_w[$];
  logic [31:0] m_fpc, m_areg;
  bit          m_out, m_disc;
  logic [31:0] m_stall, m_flush;

  // memory responder
  bit mem_busy;
  int mem_left;
  int lat_mode;

  // last sampled DUT values for the directed checks
  logic        s_req, s_valid, s_ack;
  logic [31:0] s_addr, s_pc, s_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq_pc.delete();
    mq_w.delete();
    m_fpc    = RPC;
    m_areg   = RPC;
    m_out    = 1'b0;
    m_disc   = 1'b0;
    m_stall  = '0;
    m_flush  = '0;
    mem_busy = 1'b0;
    mem_left = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #3;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    #1;
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_imem_addr", bus.imem_addr, RPC);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_instruction", bus.instruction, 32'd0);
    chk("rst_outPC", bus.outPC, 32'd0);
`ifdef FETCH_STATS_EN
    chk("rst_stall_cycles", bus.stall_cycles, 32'd0);
    chk("rst_flush_count", bus.flush_count, 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  // One clock cycle: drive controls, answer memory, compare, advance the model.
  task automatic step(input logic st, input logic rv, input logic [31:0] rpc);
    logic        e_req, e_valid, acc;
    logic [31:0] e_addr, e_pc, e_w;
    @(negedge clk);
    bus.stall = st;
    bus.redirect_valid = rv;
    bus.redirect_pc = rpc;
    #1;
    if (bus.imem_req) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_left = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      end
      bus.imem_ack = (mem_left == 0);
      if (mem_left == 0) mem_busy = 1'b0;
      else mem_left--;
      bus.imem_rdata = bus.imem_addr ^ 32'hFFFF_FFFF;
    end else begin
      mem_busy = 1'b0;
      bus.imem_ack = ($urandom_range(0, 3) == 0);
      bus.imem_rdata = $urandom;
    end
    #1;
    e_req   = m_out || ((mq_pc.size() < DEPTH) && !rv);
    e_addr  = m_out ? m_areg : m_fpc;
    e_valid = (mq_pc.size() != 0);
    e_pc    = e_valid ? mq_pc[0] : 32'd0;
    e_w     = e_valid ? mq_w[0] : 32'd0;
    chk("imem_req", 32'(bus.imem_req), 32'(e_req));
    chk("imem_addr", bus.imem_addr, e_addr);
    chk("valid", 32'(bus.valid), 32'(e_valid));
    chk("outPC", bus.outPC, e_pc);
    chk("instruction", bus.instruction, e_w);
`ifdef FETCH_STATS_EN
    chk("stall_cycles", bus.stall_cycles, m_stall);
    chk("flush_count", bus.flush_count, m_flush);
`endif
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_valid = bus.valid;
    s_pc    = bus.outPC;
    s_instr = bus.instruction;
    s_ack   = bus.imem_ack & bus.imem_req;

    acc = bus.imem_ack && e_req;
    if (e_valid && st) m_stall = m_stall + 32'd1;
    if (rv) m_flush = m_flush + 32'd1;
    if (rv) begin
      mq_pc.delete();
      mq_w.delete();
      if (m_out && !acc) m_disc = 1'b1;
      if (acc) begin
        m_out  = 1'b0;
        m_disc = 1'b0;
      end
      m_fpc = rpc & ~32'd3;
    end else begin
      if (e_valid && !st) begin
        void'(mq_pc.pop_front());
        void'(mq_w.pop_front());
      end
      if (acc) begin
        if (m_disc) m_disc = 1'b0;
        else begin
          mq_pc.push_back(e_addr);
          mq_w.push_back(e_addr ^ 32'hFFFF_FFFF);
          m_fpc = e_addr + 32'd4;
        end
        m_out = 1'b0;
      end else if (e_req && !m_out) begin
        m_out  = 1'b1;
        m_areg = m_fpc;
      end
    end
  endtask

  initial begin
    int n;
    logic [31:0] rpc;
    bus.stall = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    lat_mode = 0;
    model_reset();

    // zero-wait streaming
    do_reset();
    lat_mode = 0;
    step(1'b0, 1'b0, '0);
    chk("stream_addr0", s_addr, 32'h0040_0000);
    chk("stream_req0", 32'(s_req), 32'd1);
    step(1'b0, 1'b0, '0);
    chk("stream_addr1", s_addr, 32'h0040_0004);
    chk("stream_pc1", s_pc, 32'h0040_0000);
    chk("stream_instr1", s_instr, 32'hFFBF_FFFF);
    step(1'b0, 1'b0, '0);
    chk("stream_addr2", s_addr, 32'h0040_0008);
    chk("stream_pc2", s_pc, 32'h0040_0004);
    repeat (5) step(1'b0, 1'b0, '0);

    // stall until full, then drain
    do_reset();
    lat_mode = 0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, '0);
      n += int'(s_ack);
    end
    chk("stall_acks", 32'(n), 32'd4);
    chk("stall_req_off", 32'(s_req), 32'd0);
    chk("stall_head", s_pc, RPC);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0);
      chk("drain_pc", s_pc, RPC + 32'(4 * i));
    end

    // 3-cycle latency, redirect in the 2nd wait cycle
    do_reset();
    lat_mode = 3;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, 32'h0040_0100);
    chk("lat_hold_addr", s_addr, RPC);
    step(1'b0, 1'b0, '0);
    chk("lat_drop_ack", 32'(s_ack), 32'd1);
    chk("lat_drop_addr", s_addr, RPC);
    step(1'b0, 1'b0, '0);
    chk("lat_new_addr", s_addr, 32'h0040_0100);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, '0);
      chk("lat_still_empty", 32'(s_valid), 32'd0);
    end
    step(1'b0, 1'b0, '0);
    chk("lat_first_pc", s_pc, 32'h0040_0100);
    chk("lat_first_instr", s_instr, 32'hFFBF_FEFF);

    // redirect + ack + stall together, unaligned target
    do_reset();
    lat_mode = 1;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 32'h0040_0203);
    chk("combo_ack", 32'(s_ack), 32'd1);
    chk("combo_valid_before", 32'(s_valid), 32'd1);
    step(1'b0, 1'b0, '0);
    chk("combo_flushed", 32'(s_valid), 32'd0);
    chk("combo_next_addr", s_addr, 32'h0040_0200);
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    chk("combo_head", s_pc, 32'h0040_0200);

    // fetch address wrap
    lat_mode = 0;
    step(1'b0, 1'b1, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, '0);
    chk("wrap_addr_top", s_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b0, '0);
    chk("wrap_addr_zero", s_addr, 32'h0000_0000);
    chk("wrap_head", s_pc, 32'hFFFF_FFFC);

`ifdef FETCH_STATS_EN
    do_reset();
    lat_mode = 0;
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b0, '0);
    repeat (5) step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 32'h0040_0400);
    step(1'b0, 1'b1, 32'h0040_0800);
    step(1'b0, 1'b0, '0);
    chk("stats_stall", bus.stall_cycles, 32'd5);
    chk("stats_flush", bus.flush_count, 32'd2);
`endif

    // randomized run with a mid-handshake reset part way through
    do_reset();
    lat_mode = -1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        lat_mode = 3;
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b0, '0);
        do_reset();
        lat_mode = -1;
      end
      rpc = $urandom;
      if ($urandom_range(0, 9) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      step(($urandom_range(0, 9) < 3), ($urandom_range(0, 99) < 8), rpc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 5-stage MIPS pipeline. Owns the fetch PC, runs a req/ack handshake to instruction memory, and buffers fetched words in a small prefetch queue. Presents the head instruction and its PC as `instruction`/`outPC` to the IF/ID pipeline register, which computes PC+4 itself. Honours hazard-unit stalls and branch/jump redirects from later stages.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `DEPTH`, default 4: prefetch queue entries; power of two, at least 2.

Ports:
- `clk`  in  1  single clock; all state on posedge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `stall`  in  1  hazard unit: hold the head entry, no pop.
- `redirect_valid`  in  1  taken branch/jump; flush and refetch.
- `redirect_pc`  in  32  redirect target; bits [1:0] forced to 0.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  word-aligned fetch address.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word.
- `instruction`  out  32  head instruction; 32'h0000_0000 (NOP) when `valid`=0.
- `outPC`  out  32  PC of head instruction; 0 when `valid`=0.
- `valid`  out  1  queue non-empty.

## Operation
- State: `fpc` (next fetch address), `areg` (address of in-flight request), `inflight`, `discard`, queue of {pc, word} with `count` 0..DEPTH.
- Reset values: `fpc`=RESET_PC, queue empty, `inflight`=0, `discard`=0. Outputs: `imem_req`=0, `imem_addr`=RESET_PC, `instruction`=0, `outPC`=0, `valid`=0.
- Issue: `imem_req` = `inflight` OR (`count`<DEPTH AND NOT `redirect_valid`). `imem_addr` = `inflight` ? `areg` : `fpc`.
- Handshake: once `imem_req` is high, req and addr stay stable until the `imem_ack` cycle. Only one request is outstanding. `imem_ack` while `imem_req`=0 is ignored.
- Request accepted without ack: `inflight`<=1, `areg`<=`fpc`.
- Ack, not discarded: push {addr, `imem_rdata`}, then `fpc` <= addr+4 and `inflight`<=0.
- Ack with `discard`=1: data dropped, `discard`<=0, `inflight`<=0, `fpc` unchanged.
- Pop: when `valid` AND NOT `stall` AND NOT `redirect_valid`.
- Push and pop in the same cycle: `count` unchanged.
- Redirect: has priority over stall, pop and push.
  - Queue flushed and `fpc`<=redirect_pc & ~3.
  - If a request is outstanding and not acked this cycle: `discard`<=1.
  - If ack arrives in the redirect cycle: data dropped.
- Wrap-around: `fpc`+4 wraps modulo 2^32; queue pointers wrap modulo DEPTH.
- Full: with `count`=DEPTH no new request issues. An in-flight request cannot exist at full, because issue requires room.

## Timing
- Zero-wait memory (ack in the req cycle) gives 1 instruction/cycle sustained, with `imem_addr` advancing by 4 each cycle.
- Latency: ack in cycle M into an empty queue → `valid`=1 and the word on `instruction` in cycle M+1. Outputs come from queue registers, with no combinational path from `imem_rdata`.
- Redirect in cycle R: `valid`=0 in R+1.
  - No request outstanding: first request at the target is issued in R+1.
  - Request outstanding: first request at the target is issued in the cycle after the discarded ack.
- Reset asserted mid-handshake: request abandoned; memory must tolerate `imem_req` dropping without ack.

## Configuration
- `FETCH_STATS_EN` defined:
  - Adds outputs `stall_cycles` (32) and `flush_count` (32), both reset to 0 and wrapping.
  - `stall_cycles` increments in each cycle with `valid`=1 and `stall`=1.
  - `flush_count` increments on each `redirect_valid` cycle.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

## Test plan
- Reset, RESET_PC=32'h0040_0000, zero-wait memory returning addr^32'hFFFF_FFFF → `imem_addr` sequence 0x00400000, 0x00400004, …; from cycle 2, `instruction`/`outPC` pairs are in order, 1 per cycle.
- `stall` held 6 cycles, DEPTH=4 → exactly 4 acks accepted, then `imem_req`=0. Head stays at the same `outPC`. On release, 4 entries drain in order with no loss.
- 3-cycle memory latency, redirect to 0x00400100 in the 2nd wait cycle → `imem_addr` holds the old address until ack, that word is dropped, next request is 0x00400100, and `valid` stays 0 until its data arrives.
- Redirect, ack and `stall` in the same cycle, target 0x00400203 → queue flushed, acked word dropped, next fetch 0x00400200.
- `fpc`=32'hFFFF_FFFC → the next fetch address is 0x00000000.
- With `FETCH_STATS_EN` defined: 5 stall cycles with `valid`=1 and 2 redirects → `stall_cycles`=5, `flush_count`=2. Reset returns both to 0.
